// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes and a one-rotation scan mode.
// Optional macro DECODER_NTO2N_ERR_EN adds the err output.
module decoder_nto2n_seq #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 2**IN_W,
  parameter int SCAN_DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  de_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] de_out,
`ifdef DECODER_NTO2N_ERR_EN
  output logic             err,
`endif
  output logic             scan_busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holds valid and its payload stable until that edge, ready never waits on valid.
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [7:0]      DWELL_LAST = 8'(SCAN_DWELL - 1);
  localparam logic [IN_W-1:0] LAST_IDX   = IN_W'(OUT_W - 1);

  state_t           state_q, state_d;
  logic [OUT_W-1:0] de_out_q, de_out_d;
  logic             out_valid_q, out_valid_d;
  logic             scan_busy_q, scan_busy_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [IN_W-1:0]  beat_q, beat_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             err_d;
  logic             in_range;

  function automatic logic [OUT_W-1:0] one_hot(input logic [IN_W-1:0] i);
    return {{(OUT_W-1){1'b0}}, 1'b1} << i;
  endfunction

  assign in_range  = (32'(de_in) < OUT_W);
  assign in_ready  = en && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign de_out    = de_out_q;
  assign out_valid = out_valid_q;
  assign scan_busy = scan_busy_q;

  always_comb begin
    state_d     = state_q;
    de_out_d    = de_out_q;
    out_valid_d = out_valid_q;
    scan_busy_d = scan_busy_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    dwell_d     = dwell_q;
    err_d       = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            err_d       = !in_range;
            if (mode) begin
              // Out-of-range scan starts are clamped to output 0.
              state_d     = ST_SCAN;
              scan_busy_d = 1'b1;
              idx_d       = in_range ? de_in : '0;
              beat_d      = '0;
              dwell_d     = '0;
              de_out_d    = one_hot(idx_d);
            end else begin
              de_out_d = in_range ? one_hot(de_in) : '0;
            end
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            de_out_d    = '0;
          end
        end
        ST_SCAN: begin
          if (out_ready && (dwell_q >= DWELL_LAST)) begin
            dwell_d = '0;
            if (beat_q == LAST_IDX) begin
              state_d     = ST_IDLE;
              scan_busy_d = 1'b0;
              out_valid_d = 1'b0;
              de_out_d    = '0;
            end else begin
              idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IN_W'(1);
              beat_d   = beat_q + IN_W'(1);
              de_out_d = one_hot(idx_d);
            end
          end else if (dwell_q < DWELL_LAST) begin
            // Saturating: a stalled beat only needs to remember it has dwelt long enough.
            dwell_d = dwell_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      de_out_q    <= '0;
      out_valid_q <= 1'b0;
      scan_busy_q <= 1'b0;
      idx_q       <= '0;
      beat_q      <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      de_out_q    <= de_out_d;
      out_valid_q <= out_valid_d;
      scan_busy_q <= scan_busy_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      dwell_q     <= dwell_d;
    end
  end

`ifdef DECODER_NTO2N_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench for decoder_nto2n_seq: an OUT_W=8 and an OUT_W=6 instance share stimulus and are
// checked every cycle against a beat-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_decoder_nto2n_seq;

  localparam int DWELL = 4;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] de_in = '0;
  logic       in_ready0, out_valid0, scan_busy0;
  logic [7:0] de_out0;
  logic       in_ready1, out_valid1, scan_busy1;
  logic [5:0] de_out1;
`ifdef DECODER_NTO2N_ERR_EN
  logic       err0, err1;
`endif

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.IN_W(3), .OUT_W(8), .SCAN_DWELL(DWELL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready0), .de_in(de_in), .out_valid(out_valid0), .out_ready(out_ready),
    .de_out(de_out0),
`ifdef DECODER_NTO2N_ERR_EN
    .err(err0),
`endif
    .scan_busy(scan_busy0)
  );

  decoder_nto2n_seq #(.IN_W(3), .OUT_W(6), .SCAN_DWELL(DWELL)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready1), .de_in(de_in), .out_valid(out_valid1), .out_ready(out_ready),
    .de_out(de_out1),
`ifdef DECODER_NTO2N_ERR_EN
    .err(err1),
`endif
    .scan_busy(scan_busy1)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A scan is a list of beats: beat j shows output (start + j) mod OUT_W and must have
  // been visible for at least DWELL enabled cycles before a ready edge retires it.
  typedef struct {
    logic       valid;
    logic [7:0] out;
    logic       busy;
    logic       err;
    int         start;
    int         beat;
    int         held;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_reset();
    model_t r;
    r.valid = 1'b0; r.out = '0; r.busy = 1'b0; r.err = 1'b0;
    r.start = 0; r.beat = 0; r.held = 0;
    return r;
  endfunction

  function automatic logic [7:0] bit_at(input int k);
    logic [7:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input int outw, input logic e,
                                        input logic iv, input logic md, input logic [2:0] code,
                                        input logic ordy);
    model_t n;
    int c;
    n = m;
    c = int'(code);
    n.err = 1'b0;
    if (!e) return n;
    if (m.busy) begin
      if (ordy && m.held >= DWELL) begin
        n.beat = m.beat + 1;
        if (n.beat == outw) begin
          n.busy = 1'b0; n.valid = 1'b0; n.out = '0;
        end else begin
          n.out  = bit_at((m.start + n.beat) % outw);
          n.held = 1;
        end
      end else begin
        n.held = m.held + 1;
      end
    end else if (iv && (!m.valid || ordy)) begin
      n.valid = 1'b1;
      n.err   = (c >= outw);
      if (md) begin
        n.busy  = 1'b1;
        n.start = (c < outw) ? c : 0;
        n.beat  = 0;
        n.held  = 1;
        n.out   = bit_at(n.start);
      end else begin
        n.out = (c < outw) ? bit_at(c) : 8'h00;
      end
    end else if (ordy) begin
      n.valid = 1'b0;
      n.out   = '0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= model_reset();
      m1 <= model_reset();
    end else begin
      m0 <= model_step(m0, 8, en, in_valid, mode, de_in, out_ready);
      m1 <= model_step(m1, 6, en, in_valid, mode, de_in, out_ready);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("d0_de_out",    32'(de_out0),    32'(m0.out));
      check("d0_out_valid", 32'(out_valid0), 32'(m0.valid));
      check("d0_scan_busy", 32'(scan_busy0), 32'(m0.busy));
      check("d0_in_ready",  32'(in_ready0),  32'(en && !m0.busy && (!m0.valid || out_ready)));
      check("d0_onehot",    32'($countones(de_out0) <= 1), 32'd1);
      check("d1_de_out",    32'(de_out1),    32'(m1.out));
      check("d1_out_valid", 32'(out_valid1), 32'(m1.valid));
      check("d1_scan_busy", 32'(scan_busy1), 32'(m1.busy));
      check("d1_in_ready",  32'(in_ready1),  32'(en && !m1.busy && (!m1.valid || out_ready)));
`ifdef DECODER_NTO2N_ERR_EN
      check("d0_err", 32'(err0), 32'(m0.err));
      check("d1_err", 32'(err1), 32'(m1.err));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] beat_val [16];
  int         beat_len [16];
  int         nbeats;
  int         busy_cycles;

  // Starts a scan on the OUT_W=8 instance and records each beat value and its length.
  // en is held low for 3 cycles starting at scan cycle drop_at (negative: no drop).
  task automatic run_scan(input logic [2:0] start, input int drop_at);
    int c;
    logic [7:0] last;
    nbeats = 0;
    busy_cycles = 0;
    last = '0;
    in_valid = 1'b1; mode = 1'b1; de_in = start; out_ready = 1'b1; en = 1'b1;
    tick();
    in_valid = 1'b0; mode = 1'b0;
    for (c = 0; c < 200; c++) begin
      en = !(drop_at >= 0 && c >= drop_at && c < drop_at + 3);
      @(negedge clk);
      if (!scan_busy0) break;
      busy_cycles++;
      if (out_valid0) begin
        if (nbeats == 0 || de_out0 != last) begin
          if (nbeats < 16) begin
            beat_val[nbeats] = de_out0;
            beat_len[nbeats] = 0;
          end
          nbeats++;
        end
        if (nbeats <= 16) beat_len[nbeats-1]++;
        last = de_out0;
      end
      tick();
    end
    check("scan_timeout", 32'(c < 200), 32'd1);
    tick();
    en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] sweep_exp [8];
  logic [7:0] scan_a_exp [8];
  logic [7:0] scan_b_exp [8];
  int         len_b_exp [8];

  initial begin
    sweep_exp  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    scan_a_exp = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    scan_b_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    len_b_exp  = '{4, 4, 7, 4, 4, 4, 4, 4};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_de_out",    32'(de_out0),    32'd0);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_scan_busy", 32'(scan_busy0), 32'd0);
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;

    // direct sweep, back-to-back
    en = 1'b1; out_ready = 1'b1; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      de_in = 3'(i);
      @(negedge clk);
      check("sweep_in_ready", 32'(in_ready0), 32'd1);
      if (i > 0) check("sweep_de_out", 32'(de_out0), 32'(sweep_exp[i-1]));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sweep_de_out", 32'(de_out0), 32'(sweep_exp[7]));
    tick();

    // backpressure
    in_valid = 1'b1; de_in = 3'b101; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_de_out",    32'(de_out0),    32'(8'b00100000));
      check("bp_out_valid", 32'(out_valid0), 32'd1);
      check("bp_in_ready",  32'(in_ready0),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready0), 32'd1);
    tick();
    @(negedge clk);
    check("bp_retired", 32'(out_valid0), 32'd0);
    tick();

    // partial decode on the OUT_W=6 instance
    in_valid = 1'b1; mode = 1'b0; de_in = 3'd6;
    tick();
    de_in = 3'd7;
    @(negedge clk);
    check("part6_de_out",    32'(de_out1),    32'(6'b000000));
    check("part6_out_valid", 32'(out_valid1), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("part7_de_out",    32'(de_out1),    32'(6'b000000));
    check("part7_out_valid", 32'(out_valid1), 32'd1);
    tick();
    tick();

    // scan from 6, full rotation
    run_scan(3'd6, -1);
    check("scanA_nbeats", nbeats, 8);
    check("scanA_busy",   busy_cycles, 32);
    for (int i = 0; i < 8; i++) begin
      check("scanA_beat", 32'(beat_val[i]), 32'(scan_a_exp[i]));
      check("scanA_len",  beat_len[i], 4);
    end
    @(negedge clk);
    check("scanA_idle_de_out", 32'(de_out0), 32'd0);
    tick();

    // scan from 0 with en dropped for 3 cycles during beat 2
    run_scan(3'd0, 9);
    check("scanB_nbeats", nbeats, 8);
    check("scanB_busy",   busy_cycles, 35);
    for (int i = 0; i < 8; i++) begin
      check("scanB_beat", 32'(beat_val[i]), 32'(scan_b_exp[i]));
      check("scanB_len",  beat_len[i], len_b_exp[i]);
    end
    tick();

    // async reset during beat 3 of a scan
    in_valid = 1'b1; mode = 1'b1; de_in = 3'd0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; mode = 1'b0;
    repeat (13) tick();
    @(negedge clk);
    check("pre_rst_de_out", 32'(de_out0), 32'(8'b00001000));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_de_out",    32'(de_out0),    32'd0);
    check("arst_out_valid", 32'(out_valid0), 32'd0);
    check("arst_scan_busy", 32'(scan_busy0), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; mode = 1'b0; de_in = 3'd2;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_de_out",    32'(de_out0),    32'(8'b00000100));
    check("post_rst_out_valid", 32'(out_valid0), 32'd1);
    tick();

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      mode      = ($urandom_range(0, 9) == 0);
      de_in     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    en = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
    repeat (100) tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. Generalises the fixed 3:8 decoder to IN_W inputs and OUT_W (≤ 2**IN_W) outputs.
- Adds valid/ready handshakes on input and output, plus a scan mode that walks a one-hot pattern through every output.
- Sits between control/sequencer logic and select lines: chip-selects, row strobes, LED/mux scanning.

Parameters:
- IN_W, 3, width of binary code input; legal range 1..8.
- OUT_W, 2**IN_W, number of one-hot outputs; must satisfy 2 ≤ OUT_W ≤ 2**IN_W.
- SCAN_DWELL, 4, minimum cycles each scan beat is held valid; legal range 1..255.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, global enable; low freezes all state.
- mode, input, 1, 0 = direct decode, 1 = scan; sampled only on input handshake.
- in_valid, input, 1, de_in/mode valid.
- in_ready, output, 1, block can accept a request.
- de_in, input, IN_W, binary code (direct) or scan start index (scan).
- out_valid, output, 1, de_out holds a valid beat.
- out_ready, input, 1, consumer accepts the beat.
- de_out, output, OUT_W, registered one-hot (or all-zero) result.
- scan_busy, output, 1, high while a scan is in progress.

Behaviour:
- Reset (async, rst_n low): state = IDLE; de_out = 0; out_valid = 0; scan_busy = 0; index and dwell counters = 0. The reset takes effect immediately, including mid-scan or mid-handshake; after release the block is in IDLE with in_ready per the rule below.
- in_ready = en && state == IDLE && (!out_valid || out_ready). This is combinational from registered state and out_ready.
- Input handshake: in_valid && in_ready on the same rising edge.
- FSM states: IDLE, SCAN.
- Direct mode (mode = 0 at handshake):
  - Next cycle: de_out = 1 << de_in; out_valid = 1; state stays IDLE.
  - Latency is 1 cycle. Back-to-back accepts are allowed when out_ready = 1, giving one beat per cycle.
- Out-of-range code (de_in ≥ OUT_W) in direct mode: de_out = 0, out_valid = 1. The beat is still delivered so the handshake count is preserved.
- Output hold: while out_valid && !out_ready, de_out and out_valid are stable.
- out_valid clears on out_ready unless a new beat is loaded on the same edge.
- Scan mode (mode = 1 at handshake):
  - Transition IDLE → SCAN; scan_busy = 1 from the next cycle.
  - Start index = de_in, or 0 if de_in ≥ OUT_W.
  - Each beat: de_out = one-hot(index), out_valid = 1. The dwell counter counts cycles the beat has been valid.
  - A beat retires only when out_ready = 1 and the dwell count ≥ SCAN_DWELL − 1, i.e. it is held at least SCAN_DWELL cycles.
  - On retire, index increments, wrapping OUT_W−1 → 0, and the dwell counter clears.
  - Exactly OUT_W beats are issued, one full rotation.
  - After the OUT_W-th beat retires: out_valid = 0, de_out = 0, scan_busy = 0, SCAN → IDLE. in_ready can re-assert the following cycle.
- en = 0: no state, counter, or output changes. The dwell counter does not advance, in_ready = 0, and the output beat is held; out_ready is ignored.
- A handshake with in_valid and mode changing mid-scan is impossible, because in_ready = 0 in SCAN.
- de_out always has at most one bit set.

Optional Feature:
- Macro DECODER_NTO2N_ERR_EN.
- Defined: extra output port err (1 bit, reset 0). err pulses high for exactly 1 cycle, aligned with the cycle out_valid first presents a beat, when the accepted de_in was ≥ OUT_W. This covers both a direct decode and a clamped scan start.
- Not defined: no err port; out-of-range codes are handled silently as above.

Test Plan:
- Reset and direct sweep, IN_W = 3, OUT_W = 8, out_ready = 1: hold rst_n low, check de_out = 0, out_valid = 0. Release, then apply de_in = 0..7 back-to-back → de_out = 8'b00000001 … 8'b10000000 one cycle after each accept, in_ready constantly 1.
- Backpressure: de_in = 3'b101 with out_ready = 0 for 5 cycles → de_out = 8'b00100000 stable, out_valid = 1, in_ready = 0. Raise out_ready → beat retires, in_ready = 1.
- Partial decode, OUT_W = 6: de_in = 6 and then 7 → de_out = 6'b000000 with out_valid = 1 each. With DECODER_NTO2N_ERR_EN defined, err pulses once per beat.
- Scan, OUT_W = 8, SCAN_DWELL = 4, start de_in = 6, out_ready = 1:
  - Beats 01000000, 10000000, 00000001 … 00100000: 8 beats, each held exactly 4 cycles.
  - scan_busy high 32 cycles; then IDLE, de_out = 0.
- Scan with en dropped for 3 cycles mid-beat → beat length extended by exactly 3 cycles, no beat skipped.
- Async reset asserted mid-scan (beat 3) → de_out = 0, out_valid = 0, scan_busy = 0 immediately, without waiting for clk. After release, a direct de_in = 2 → 8'b00000100.
